vga_tile_render: RTL and testbench
==================================

# vga_tile_render

Pixel-colour generator for game mode. Takes the pixel counters and syncs from the VGA timing generator, reads the 20×15 board map from the map RAM, and produces the 3-bit `GColor` consumed by the VGA colour mux, together with syncs delayed to stay aligned with it. Each tile is 32×32 pixels and is drawn with a fixed per-type pattern. A frame counter blinks target markers.

## Interface
- `MAP_W`, 20: board width in tiles
- `MAP_H`, 15: board height in tiles
- `ADDR_W`, 9: map RAM address width
- `clk` input 1: system clock
- `rst_n` input 1: asynchronous, active-low reset
- `pix_en` input 1: pixel strobe; the pipeline advances only when it is high; successive strobes may be on consecutive clocks
- `hcnt` input 10: pixel column, 0–639 visible
- `vcnt` input 10: pixel row, 0–479 visible
- `video_on` input 1: visible-area flag
- `hs_in`, `vs_in` input 1: syncs, active-low
- `map_addr` output ADDR_W: map RAM read address
- `map_data` input 3: tile type; synchronous RAM, valid one clk after `map_addr` changes
- `GColor` output 3: {R,G,B}
- `hs_out`, `vs_out` output 1: syncs delayed to match `GColor`
- `video_on_out` output 1: delayed visible flag

## Operation
- Tile coordinates: `col = hcnt[9:5]`, `row = vcnt[9:5]`. In-tile offsets: `px = hcnt[4:0]`, `py = vcnt[4:0]`.
- Address: `row*20 + col`, computed as `(row<<4)+(row<<2)+col`, 9 bits, no overflow for in-range tiles.
- Out of range: if `col ≥ MAP_W` or `row ≥ MAP_H`, set `in_map = 0`. `map_addr` holds its previous value and the pixel is drawn as type 7.
- Tile types and patterns:
  - 0, floor: 000.
  - 1, wall: 100. Mortar pixels are 111. A pixel is mortar when `py[2:0]==0` or `px[3:0]=={py[3],3'b000}`.
  - 2, box: fill 110. Border 100, where the border is `px` or `py` equal to 0 or 31.
  - 3, target: 000. Dot 010 when `px,py ∈ [12,19]` and `blink==0`.
  - 4, box on target: box pattern with fill 010 and border 100.
  - 5, player: diamond 001, otherwise 000.
    - Define `dx = px[4] ? px-16 : 15-px` and `dy` likewise, each 4 bits.
    - A pixel is in the diamond when the 5-bit sum `dx+dy ≤ 13`.
  - 6, player on target: diamond 001. Outside the diamond, apply the target dot rule.
  - 7, reserved/outside: 000.
- When delayed `video_on` is 0, `GColor` is forced to 000.
- Frame counter:
  - 6-bit `frame_cnt`. It increments on a `pix_en` cycle in which `vs_in==0` and the registered previous `vs_in==1` (falling edge).
  - It wraps 63→0.
  - `blink = frame_cnt[5]`, i.e. 32 frames on, 32 frames off.

## Timing
- Stage A (on `pix_en`): registers `map_addr` (if `in_map`), `px`, `py`, `in_map`, `video_on`, `hs_in`, `vs_in`.
- Stage B (on `pix_en`): decodes `map_data` with the stage-A registers and registers `GColor`, `hs_out`, `vs_out`, `video_on_out`.
- Latency is exactly 2 `pix_en` strobes, identical for colour and syncs.
- When `pix_en` is low, all registers hold.
- Reset values:
  - `map_addr` = 0, `GColor` = 000
  - `hs_out` = 1, `vs_out` = 1, `video_on_out` = 0
  - `frame_cnt` = 0, previous-`vs` register = 1, all stage-A registers inactive/zero
- Reset mid-frame: outputs go immediately (asynchronously) to their reset values. After release, the first valid colour appears at the 2nd strobe.
- A `vs` falling edge coincident with any pixel is counted once. A held-low `vs` does not re-count.

## Structure
- Shared package (header/include): tile-type constants `T_FLOOR`..`T_RSVD`, colour constants `C_BLACK`, `C_RED`, `C_YELLOW`, `C_GREEN`, `C_BLUE`, `C_WHITE`, and `MAP_W`/`MAP_H`.
- Sub-module `tile_pattern`: purely combinational; maps (type, `px`, `py`, `blink`) to the 3-bit colour. It is instantiated in stage B.

## Test plan
- Reset: hold `rst_n=0` mid-line → `GColor=000`, `hs_out=vs_out=1`, `video_on_out=0`. Release → the first pixel colour appears 2 strobes after the first `pix_en`.
- Address: `hcnt=640-1`, `vcnt=479` → `map_addr=299`. `hcnt=32`, `vcnt=64` → `map_addr=41`. `hcnt=700` → `map_addr` unchanged and `GColor=000`.
- Wall pattern with RAM model returning 1: `px=5,py=0` → 111; `px=5,py=1` → 100; `px=8,py=9` → 111 (offset row); `px=0,py=9` → 100.
- Box/player with RAM returning 4: `px=0` → 100; `px=10,py=10` → 010. With RAM returning 5: `px=py=15` → 001; `px=py=0` → 000.
- Blink with RAM returning 3 at `px=py=16`: → 010 for frames 0–31, 000 for frames 32–63, 010 again after 64 `vs` falling edges (wrap).
- Stall/alignment: random `pix_en` gaps, including back-to-back strobes → `hs_out`/`vs_out`/`video_on_out` equal the inputs delayed exactly 2 strobes, and `GColor` matches the scoreboard model every strobe.

Source files
------------

// File: rtl/vga_tile_render_pkg.sv
// Shared definitions for the game-mode tile renderer: tile types, colours,
// board geometry and the player-diamond helper.
package vga_tile_render_pkg;

  localparam int MAP_W = 20;
  localparam int MAP_H = 15;

  typedef enum logic [2:0] {
    T_FLOOR   = 3'd0,
    T_WALL    = 3'd1,
    T_BOX     = 3'd2,
    T_TARGET  = 3'd3,
    T_BOX_TGT = 3'd4,
    T_PLAYER  = 3'd5,
    T_PLY_TGT = 3'd6,
    T_RSVD    = 3'd7
  } tile_t;

  // Colours are {R,G,B}.
  localparam logic [2:0] C_BLACK  = 3'b000;
  localparam logic [2:0] C_RED    = 3'b100;
  localparam logic [2:0] C_YELLOW = 3'b110;
  localparam logic [2:0] C_GREEN  = 3'b010;
  localparam logic [2:0] C_BLUE   = 3'b001;
  localparam logic [2:0] C_WHITE  = 3'b111;

  // Distance from the tile centre folds each half onto 0..15; the diamond is
  // every pixel whose folded Manhattan distance is at most 13.
  function automatic logic in_diamond(input logic [4:0] px, input logic [4:0] py);
    logic [3:0] dx;
    logic [3:0] dy;
    dx = px[4] ? px[3:0] : ~px[3:0];
    dy = py[4] ? py[3:0] : ~py[3:0];
    return ({1'b0, dx} + {1'b0, dy}) <= 5'd13;
  endfunction

endpackage

// File: rtl/tile_pattern.sv
// Combinational per-tile pattern: maps tile type, in-tile offset and the blink
// phase to a 3-bit colour.
module tile_pattern
  import vga_tile_render_pkg::*;
(
  input  tile_t      tile_type,
  input  logic [4:0] px,
  input  logic [4:0] py,
  input  logic       blink,
  output logic [2:0] color
);

  logic mortar;
  logic border;
  logic dot;
  logic diamond;

  // Bricks are 16 wide and 8 high; every other course is offset by half a brick.
  assign mortar  = (py[2:0] == 3'd0) || (px[3:0] == {py[3], 3'b000});
  assign border  = (px == 5'd0) || (px == 5'd31) || (py == 5'd0) || (py == 5'd31);
  assign dot     = (px >= 5'd12) && (px <= 5'd19) && (py >= 5'd12) && (py <= 5'd19) && !blink;
  assign diamond = in_diamond(px, py);

  always_comb begin
    // NOTE: assigning a default before the case guarantees every path drives
    // color, so no latch can be inferred.
    color = C_BLACK;
    case (tile_type)
      T_WALL:    color = mortar ? C_WHITE : C_RED;
      T_BOX:     color = border ? C_RED : C_YELLOW;
      T_TARGET:  color = dot ? C_GREEN : C_BLACK;
      T_BOX_TGT: color = border ? C_RED : C_GREEN;
      T_PLAYER:  color = diamond ? C_BLUE : C_BLACK;
      T_PLY_TGT: color = diamond ? C_BLUE : (dot ? C_GREEN : C_BLACK);
      default:   color = C_BLACK;
    endcase
  end

endmodule

// File: rtl/vga_tile_render.sv
// Game-mode pixel colour generator: two pix_en-gated stages (map address, then
// pattern decode) with syncs and the visible flag delayed to stay aligned.
module vga_tile_render
  import vga_tile_render_pkg::tile_t;
  import vga_tile_render_pkg::T_RSVD;
  import vga_tile_render_pkg::C_BLACK;
#(
  parameter int MAP_W  = 20,
  parameter int MAP_H  = 15,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [9:0]        hcnt,
  input  logic [9:0]        vcnt,
  input  logic              video_on,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic [ADDR_W-1:0] map_addr,
  input  logic [2:0]        map_data,
  output logic [2:0]        GColor,
  output logic              hs_out,
  output logic              vs_out,
  output logic              video_on_out
);

  logic [4:0]        col;
  logic [4:0]        row;
  logic              in_map;
  logic [ADDR_W-1:0] row_w;
  logic [ADDR_W-1:0] col_w;
  logic [ADDR_W-1:0] addr_calc;

  assign col    = hcnt[9:5];
  assign row    = vcnt[9:5];
  assign in_map = (int'(col) < MAP_W) && (int'(row) < MAP_H);

  // row*20 as shift-and-add; cannot overflow for in-map tiles.
  assign row_w     = ADDR_W'(row);
  assign col_w     = ADDR_W'(col);
  assign addr_calc = (row_w << 4) + (row_w << 2) + col_w;

  // Stage A registers.
  logic [4:0] px_a;
  logic [4:0] py_a;
  logic       in_map_a;
  logic       vid_a;
  logic       hs_a;
  logic       vs_a;
  logic [5:0] frame_cnt;

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_addr <= '0;
      px_a     <= '0;
      py_a     <= '0;
      in_map_a <= 1'b0;
      vid_a    <= 1'b0;
      hs_a     <= 1'b1;
      vs_a     <= 1'b1;
    end else if (pix_en) begin
      if (in_map) map_addr <= addr_calc;
      px_a     <= hcnt[4:0];
      py_a     <= vcnt[4:0];
      in_map_a <= in_map;
      vid_a    <= video_on;
      hs_a     <= hs_in;
      vs_a     <= vs_in;
    end
  end

  // The stage-A vs register doubles as the previous-vs sample for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (pix_en && !vs_in && vs_a) begin
      frame_cnt <= frame_cnt + 6'd1;
    end
  end

  tile_t      tile_type;
  logic [2:0] pat_color;

  assign tile_type = in_map_a ? tile_t'(map_data) : T_RSVD;

  tile_pattern u_pattern (
    .tile_type (tile_type),
    .px        (px_a),
    .py        (py_a),
    .blink     (frame_cnt[5]),
    .color     (pat_color)
  );

  // Stage B registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      GColor       <= C_BLACK;
      hs_out       <= 1'b1;
      vs_out       <= 1'b1;
      video_on_out <= 1'b0;
    end else if (pix_en) begin
      GColor       <= vid_a ? pat_color : C_BLACK;
      hs_out       <= hs_a;
      vs_out       <= vs_a;
      video_on_out <= vid_a;
    end
  end

endmodule

// File: tb/tb_vga_tile_render.sv
// Scoreboard bench for vga_tile_render: the driver pushes expected results from
// an arithmetic reference model, an independent monitor pops them on each strobe.
module tb_vga_tile_render;

  logic       clk;
  logic       rst_n;
  logic       pix_en;
  logic [9:0] hcnt;
  logic [9:0] vcnt;
  logic       video_on;
  logic       hs_in;
  logic       vs_in;
  logic [8:0] map_addr;
  logic [2:0] map_data;
  logic [2:0] GColor;
  logic       hs_out;
  logic       vs_out;
  logic       video_on_out;

  vga_tile_render #(.MAP_W(20), .MAP_H(15), .ADDR_W(9)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pix_en       (pix_en),
    .hcnt         (hcnt),
    .vcnt         (vcnt),
    .video_on     (video_on),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .map_addr     (map_addr),
    .map_data     (map_data),
    .GColor       (GColor),
    .hs_out       (hs_out),
    .vs_out       (vs_out),
    .video_on_out (video_on_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Map RAM: read data settles within the clock after map_addr changes.
  logic [2:0] mem [512];
  assign map_data = mem[map_addr];

  typedef struct packed {
    logic [2:0] col;
    logic       hs;
    logic       vs;
    logic       vid;
  } exp_t;

  exp_t exp_q[$];
  int   addr_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference-model state.
  int   exp_addr;
  int   vs_edges;
  logic prev_vs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_colour(input int t, input int px, input int py, input bit blink);
    bit dot;
    bit edge_px;
    int dx;
    int dy;
    dot     = px >= 12 && px <= 19 && py >= 12 && py <= 19 && !blink;
    edge_px = px == 0 || px == 31 || py == 0 || py == 31;
    dx      = (px >= 16) ? px - 16 : 15 - px;
    dy      = (py >= 16) ? py - 16 : 15 - py;
    case (t)
      1:       return ((py % 8 == 0) || (px % 16 == 8 * ((py / 8) % 2))) ? 3'b111 : 3'b100;
      2:       return edge_px ? 3'b100 : 3'b110;
      3:       return dot ? 3'b010 : 3'b000;
      4:       return edge_px ? 3'b100 : 3'b010;
      5:       return (dx + dy <= 13) ? 3'b001 : 3'b000;
      6:       return (dx + dy <= 13) ? 3'b001 : (dot ? 3'b010 : 3'b000);
      default: return 3'b000;
    endcase
  endfunction

  task automatic fill_mem(input int mode);
    for (int i = 0; i < 512; i++) mem[i] = (mode < 8) ? 3'(mode) : 3'($urandom_range(0, 7));
  endtask

  // One pixel strobe; force_col >= 0 replaces the model colour with a known constant.
  task automatic send(input int h, input int v, input logic hs, input logic vs, input int force_col);
    int   col;
    int   row;
    bit   inm;
    logic vid;
    int   t;
    logic [2:0] c;
    @(negedge clk);
    hcnt     = 10'(h);
    vcnt     = 10'(v);
    vid      = (h < 640) && (v < 480);
    video_on = vid;
    hs_in    = hs;
    vs_in    = vs;
    pix_en   = 1'b1;
    col = h / 32;
    row = v / 32;
    inm = (col < 20) && (row < 15);
    if (inm) exp_addr = row * 20 + col;
    addr_q.push_back(exp_addr);
    if (vs == 1'b0 && prev_vs == 1'b1) vs_edges++;
    prev_vs = vs;
    t = inm ? int'(mem[row * 20 + col]) : 7;
    c = vid ? ref_colour(t, h % 32, v % 32, ((vs_edges % 64) >= 32)) : 3'b000;
    if (force_col >= 0) c = 3'(force_col);
    exp_q.push_back('{col: c, hs: hs, vs: vs, vid: vid});
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_en   = 1'b0;
      hcnt     = 10'($urandom_range(0, 799));
      vcnt     = 10'($urandom_range(0, 524));
      video_on = 1'($urandom);
      hs_in    = 1'($urandom);
      vs_in    = 1'($urandom);
      @(posedge clk);
    end
  endtask

  // Asynchronous reset asserted between clock edges; outputs must react at once.
  task automatic do_reset();
    @(negedge clk);
    pix_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_gcolor", 32'(GColor), 32'd0);
    check("rst_hs_out", 32'(hs_out), 32'd1);
    check("rst_vs_out", 32'(vs_out), 32'd1);
    check("rst_video_on_out", 32'(video_on_out), 32'd0);
    check("rst_map_addr", 32'(map_addr), 32'd0);
    exp_q.delete();
    addr_q.delete();
    exp_addr = 0;
    vs_edges = 0;
    prev_vs  = 1'b1;
    // First strobe after reset shifts out the idle stage-A contents.
    exp_q.push_back('{col: 3'b000, hs: 1'b1, vs: 1'b1, vid: 1'b0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every strobe presents one output and one map address.
  initial begin
    exp_t e;
    int   a;
    forever begin
      @(posedge clk);
      if (rst_n && pix_en) begin
        #1;
        if (exp_q.size() == 0 || addr_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL scoreboard_empty: output strobe with no expected entry (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          a = addr_q.pop_front();
          check("gcolor", 32'(GColor), 32'(e.col));
          check("hs_out", 32'(hs_out), 32'(e.hs));
          check("vs_out", 32'(vs_out), 32'(e.vs));
          check("video_on_out", 32'(video_on_out), 32'(e.vid));
          check("map_addr", 32'(map_addr), 32'(a));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    pix_en   = 1'b0;
    hcnt     = 10'd100;
    vcnt     = 10'd50;
    video_on = 1'b1;
    hs_in    = 1'b1;
    vs_in    = 1'b1;
    exp_addr = 0;
    vs_edges = 0;
    prev_vs  = 1'b1;
    fill_mem(8);

    // Address mapping, including the last tile and an out-of-map column.
    do_reset();
    send(639, 479, 1'b1, 1'b1, -1);
    send(32, 64, 1'b1, 1'b1, -1);
    idle(2);
    send(700, 100, 1'b1, 1'b1, 0);
    send(700, 100, 1'b0, 1'b1, 0);
    send(100, 500, 1'b1, 1'b1, 0);
    idle(3);

    // Wall pattern in tile (3,2).
    do_reset();
    fill_mem(1);
    send(96 + 5, 64 + 0, 1'b1, 1'b1, 3'b111);
    send(96 + 5, 64 + 1, 1'b1, 1'b1, 3'b100);
    idle(1);
    send(96 + 8, 64 + 9, 1'b1, 1'b1, 3'b111);
    send(96 + 0, 64 + 9, 1'b1, 1'b1, 3'b100);
    idle(2);

    // Box on target, then player.
    do_reset();
    fill_mem(4);
    send(96 + 0, 64 + 10, 1'b1, 1'b1, 3'b100);
    send(96 + 10, 64 + 10, 1'b1, 1'b1, 3'b010);
    idle(2);
    do_reset();
    fill_mem(5);
    send(96 + 15, 64 + 15, 1'b1, 1'b1, 3'b001);
    send(96 + 0, 64 + 0, 1'b1, 1'b1, 3'b000);
    idle(2);

    // Target blink across a full 64-frame wrap.
    do_reset();
    fill_mem(3);
    for (int f = 0; f < 66; f++) begin
      send(96 + 16, 64 + 16, 1'b1, 1'b1, ((f % 64) < 32) ? 3'b010 : 3'b000);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(96 + 16, 64 + 16, 1'b1, 1'b0, -1);
      send(96 + 16, 64 + 16, 1'b1, 1'b0, -1);
    end
    idle(2);

    // Random traffic with stalls, back-to-back strobes and a mid-frame reset.
    do_reset();
    fill_mem(8);
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        do_reset();
        fill_mem(8);
      end
      if ($urandom_range(0, 2) != 0) begin
        send($urandom_range(0, 799), $urandom_range(0, 524),
             1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 4) != 0), -1);
      end else begin
        idle($urandom_range(1, 3));
      end
    end
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
